// File: rtl/mult_unit_pkg.sv
// Shared ALU definitions: control codes for the control decoder and the
// multiply unit, plus the multiply FSM state encoding.
//   AluXxx     4-bit alu_ctrl codes
//   mult_state_e  multiply FSM states
//   is_mult_op    true for codes owned by the multiply unit
package mult_unit_pkg;

  localparam logic [3:0] AluAnd   = 4'b0000;
  localparam logic [3:0] AluOr    = 4'b0001;
  localparam logic [3:0] AluAdd   = 4'b0010;
  localparam logic [3:0] AluSub   = 4'b0110;
  localparam logic [3:0] AluSlt   = 4'b0111;
  localparam logic [3:0] AluNor   = 4'b1100;
  localparam logic [3:0] AluMultu = 4'b1001;
  localparam logic [3:0] AluMfhi  = 4'b1010;
  localparam logic [3:0] AluMflo  = 4'b1011;

  // One shift-add step per operand bit.
  localparam int unsigned MultSteps = 32;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } mult_state_e;

  function automatic logic is_mult_op(input logic [3:0] code);
    return (code == AluMultu) || (code == AluMfhi) || (code == AluMflo);
  endfunction

endpackage

// File: rtl/mult_unit_step.sv
// One combinational shift-add multiply step.
//   product       current 64-bit product register {partial hi, multiplier lo}
//   mcand         latched 32-bit multiplicand
//   next_product  product after conditional add into [63:32] and right shift
module mult_step (
  input  logic [63:0] product,
  input  logic [31:0] mcand,
  output logic [63:0] next_product
);

  logic [32:0] sum;

  always_comb begin
    sum = {1'b0, product[63:32]} + (product[0] ? {1'b0, mcand} : 33'd0);
    // Shifting {carry, sum[31:0], product} right by one drops product[0].
    next_product = {sum, product[31:1]};
  end

endmodule

// File: rtl/mult_unit.sv
// Sequential 32x32 unsigned multiplier with architectural HI/LO registers.
//   clk, rst       clock, asynchronous active-high reset
//   alu_ctrl,start issued ALU op (MULTU / MFHI / MFLO handled here)
//   a, b           multiplicand / multiplier
//   busy, stall    multiply in progress / pipeline hold request
//   done           one-cycle pulse after HI/LO take a new product
//   rd_data        MFHI/MFLO read data
//   hi, lo         architectural HI/LO registers
module mult_unit
  import mult_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  alu_ctrl,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mult_state_e state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic [63:0] step_prod;

  mult_step u_step (
    .product      (prod_q),
    .mcand        (mcand_q),
    .next_product (step_prod)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && (alu_ctrl == AluMultu)) begin
          mcand_d = a;
          prod_d  = {32'h0, b};
          cnt_d   = 5'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        prod_d = step_prod;
        cnt_d  = cnt_q + 5'd1;
        if (cnt_q == 5'(MultSteps - 1)) begin
          // Only the finished product ever reaches HI/LO.
          hi_d    = step_prod[63:32];
          lo_d    = step_prod[31:0];
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 5'd0;
      prod_q  <= 64'h0;
      mcand_q <= 32'h0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q == StRun);
  assign stall = busy && start && is_mult_op(alu_ctrl);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

  always_comb begin
    rd_data = 32'h0;
    if (alu_ctrl == AluMfhi) begin
      rd_data = hi_q;
    end else if (alu_ctrl == AluMflo) begin
      rd_data = lo_q;
    end
  end

endmodule

// File: tb/tb_mult_unit.sv
module tb_mult_unit;
  import mult_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  alu_ctrl;
  logic        start;
  logic [31:0] a, b;
  logic        busy, stall, done;
  logic [31:0] rd_data, hi, lo;

  int total = 0;
  int bad   = 0;

  mult_unit dut (
    .clk      (clk),
    .rst      (rst),
    .alu_ctrl (alu_ctrl),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .rd_data  (rd_data),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    return {32'h0, x} * {32'h0, y};
  endfunction

  // Advance negedge by negedge until done rises (bounded); reports HI/LO or busy anomalies.
  task automatic wait_done(input logic [31:0] hi0, input logic [31:0] lo0,
                           output int cyc, output bit moved, output bit gap);
    cyc = 0; moved = 0; gap = 0;
    while (done !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done !== 1'b1) begin
        if (hi !== hi0 || lo !== lo0) moved = 1;
        if (busy !== 1'b1) gap = 1;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; alu_ctrl = AluMfhi; a = '0; b = '0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got %b want 0", done); end
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin
      bad++; $display("FAIL rst_hilo got %h_%h want 0_0", hi, lo); end
    total++; if (rd_data !== 32'h0) begin bad++; $display("FAIL rst_rd got %h want 0", rd_data); end
    rst = 1'b0; alu_ctrl = AluAdd;
    @(negedge clk);
    total++; if (busy !== 1'b0 || stall !== 1'b0) begin
      bad++; $display("FAIL post_rst_idle got busy=%b stall=%b want 0 0", busy, stall); end
  endtask

  task automatic test_multu(input logic [31:0] ta, input logic [31:0] tb, input string nm);
    logic [63:0] exp;
    logic [31:0] hi0, lo0;
    int cyc; bit moved, gap;
    exp = ref_mul(ta, tb);
    hi0 = hi; lo0 = lo;
    start = 1'b1; alu_ctrl = AluMultu; a = ta; b = tb;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL %s idle_stall got %b want 0", nm, stall); end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; alu_ctrl = AluAdd; a = $urandom; b = $urandom;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL %s busy_e0 got %b want 1", nm, busy); end
    wait_done(hi0, lo0, cyc, moved, gap);
    total++; if (cyc !== 32) begin bad++; $display("FAIL %s latency got %0d want 32", nm, cyc); end
    total++; if (moved || gap) begin
      bad++; $display("FAIL %s run_hilo_busy got moved=%b gap=%b want 0 0", nm, moved, gap); end
    total++; if (hi !== exp[63:32] || lo !== exp[31:0]) begin
      bad++; $display("FAIL %s result got %h_%h want %h_%h", nm, hi, lo, exp[63:32], exp[31:0]); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_end got %b want 0", nm, busy); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL %s done_width got %b want 0", nm, done); end
  endtask

  task automatic test_basic;
    test_multu(32'd3, 32'd5, "mul3x5");
    total++; if (hi !== 32'h0 || lo !== 32'd15) begin
      bad++; $display("FAIL mul3x5_const got %h_%h want 0_f", hi, lo); end
  endtask

  task automatic test_corners;
    test_multu(32'h12345678, 32'h0, "mul_b0");
    test_multu(32'h0, 32'hDEADBEEF, "mul_a0");
    test_multu(32'hFFFFFFFF, 32'hFFFFFFFF, "mul_max");
    total++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      bad++; $display("FAIL mul_max_const got %h_%h want fffffffe_00000001", hi, lo); end
  endtask

  task automatic test_noop;
    logic [31:0] hi0, lo0, want;
    bit flag;
    hi0 = hi; lo0 = lo; flag = 0;
    for (int c = 0; c < 16; c++) begin
      alu_ctrl = 4'(c); start = (c == 9) ? 1'b0 : 1'($urandom); a = $urandom; b = $urandom;
      want = (c == 10) ? hi0 : (c == 11) ? lo0 : 32'h0;
      #1;
      if (rd_data !== want || stall !== 1'b0) flag = 1;
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0 || hi !== hi0 || lo !== lo0) flag = 1;
    end
    total++; if (flag) begin bad++; $display("FAIL noop_codes got disturbed=1 want 0"); end
    start = 1'b0; alu_ctrl = AluAdd;
  endtask

  task automatic test_stall_mfhi;
    logic [31:0] ta, tb;
    logic [63:0] exp;
    int n; bit sbad;
    ta = $urandom; tb = $urandom; exp = ref_mul(ta, tb);
    start = 1'b1; alu_ctrl = AluMultu; a = ta; b = tb;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; alu_ctrl = AluAdd;
    repeat (4) @(negedge clk);
    start = 1'b1; alu_ctrl = AluMfhi;
    n = 0; sbad = 0;
    while (busy === 1'b1 && n < 40) begin
      #1; if (stall !== 1'b1) sbad = 1;
      @(negedge clk); n++;
    end
    total++; if (sbad) begin bad++; $display("FAIL mfhi_stall got gap=1 want 0"); end
    total++; if (n !== 28) begin bad++; $display("FAIL mfhi_stall_len got %0d want 28", n); end
    #1;
    total++; if (stall !== 1'b0 || done !== 1'b1) begin
      bad++; $display("FAIL mfhi_release got stall=%b done=%b want 0 1", stall, done); end
    total++; if (rd_data !== exp[63:32]) begin
      bad++; $display("FAIL mfhi_data got %h want %h", rd_data, exp[63:32]); end
    alu_ctrl = AluMflo; #1;
    total++; if (rd_data !== exp[31:0]) begin
      bad++; $display("FAIL mflo_data got %h want %h", rd_data, exp[31:0]); end
    start = 1'b0; alu_ctrl = AluAdd;
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    bit flag;
    test_multu(32'hCAFEBABE, 32'h01234567, "pre_abort");
    start = 1'b1; alu_ctrl = AluMultu; a = $urandom; b = $urandom;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; alu_ctrl = AluAdd;
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL abort_ctrl got busy=%b done=%b want 0 0", busy, done); end
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin
      bad++; $display("FAIL abort_hilo got %h_%h want 0_0", hi, lo); end
    @(negedge clk);
    rst = 1'b0;
    flag = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) flag = 1;
    end
    total++; if (flag) begin bad++; $display("FAIL abort_quiet got activity=1 want 0"); end
    test_multu(32'd7, 32'd9, "after_abort");
    total++; if (lo !== 32'd63 || hi !== 32'h0) begin
      bad++; $display("FAIL mul7x9 got %h_%h want 0_3f", hi, lo); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a1, b1, a2, b2;
    logic [63:0] e1, e2;
    int n, cyc; bit sbad, moved, gap;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    e1 = ref_mul(a1, b1); e2 = ref_mul(a2, b2);
    start = 1'b1; alu_ctrl = AluMultu; a = a1; b = b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; alu_ctrl = AluAdd;
    repeat (2) @(negedge clk);
    start = 1'b1; alu_ctrl = AluMultu; a = a2; b = b2;
    n = 0; sbad = 0;
    while (busy === 1'b1 && n < 40) begin
      #1; if (stall !== 1'b1) sbad = 1;
      @(negedge clk); n++;
    end
    total++; if (sbad || n !== 30) begin
      bad++; $display("FAIL b2b_stall got gap=%b len=%0d want 0 30", sbad, n); end
    total++; if (done !== 1'b1 || stall !== 1'b0) begin
      bad++; $display("FAIL b2b_done got done=%b stall=%b want 1 0", done, stall); end
    total++; if (hi !== e1[63:32] || lo !== e1[31:0]) begin
      bad++; $display("FAIL b2b_first got %h_%h want %h_%h", hi, lo, e1[63:32], e1[31:0]); end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; alu_ctrl = AluAdd; a = $urandom; b = $urandom;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept got %b want 1", busy); end
    wait_done(e1[63:32], e1[31:0], cyc, moved, gap);
    total++; if (cyc !== 32 || moved || gap) begin
      bad++; $display("FAIL b2b_second_run got cyc=%0d moved=%b gap=%b want 32 0 0", cyc, moved, gap);
    end
    total++; if (hi !== e2[63:32] || lo !== e2[31:0]) begin
      bad++; $display("FAIL b2b_second got %h_%h want %h_%h", hi, lo, e2[63:32], e2[31:0]); end
    @(negedge clk);
  endtask

  task automatic test_random;
    for (int i = 0; i < 6; i++) begin
      test_multu($urandom, $urandom, "rand");
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_corners;
    test_noop;
    test_stall_mfhi;
    test_reset_abort;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
